// File: rtl/crc_pkg.sv
// crc_pkg: shared types and the LFSR step for the bit-serial CRC engine.
//   state_e   : engine FSM states (IDLE, SHIFT)
//   crc_step  : one MSB-first division step of the remainder register,
//               width-parametrised through the w argument (w <= CRC_MAX_W)
package crc_pkg;

  localparam int unsigned CRC_MAX_W = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Feed one message bit into a w-bit remainder. The implicit x^w term of
  // the generator is what makes fb select whether POLY gets folded in.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] rem,
    input logic                 b,
    input logic [CRC_MAX_W-1:0] poly,
    input int unsigned          w
  );
    logic                 fb;
    logic [CRC_MAX_W-1:0] mask;
    logic [CRC_MAX_W-1:0] nxt;
    fb   = rem[w-1] ^ b;
    mask = (w >= CRC_MAX_W) ? '1 : ((CRC_MAX_W'(1) << w) - CRC_MAX_W'(1));
    nxt  = (rem << 1) ^ (fb ? poly : '0);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/crc_serial_engine.sv
// crc_serial_engine: bit-serial CRC generator/checker, one message bit per
// clock, MSB first.
//   i_clk, i_rst_n  : clock (rising edge), async active-low reset
//   i_start/o_ready : request handshake, accept on i_start & o_ready
//   i_mode          : 0 = generate, 1 = check (sampled on accept)
//   i_data, i_crc   : message word and received CRC (sampled on accept)
//   i_abort         : drop the word in progress, no result
//   o_done          : one-cycle pulse, result valid
//   o_crc_code      : final remainder, held until the next o_done
//   o_crc_err       : check mode remainder mismatch, held with o_crc_code
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int unsigned          DATA_W = 8,
  parameter int unsigned          CRC_W  = 4,
  parameter logic [CRC_W-1:0]     POLY   = 4'h7,
  parameter logic [CRC_W-1:0]     INIT   = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CRC_W-1:0]  i_crc,
  input  logic              i_abort,
  output logic              o_ready,
  output logic              o_done,
  output logic [CRC_W-1:0]  o_crc_code,
  output logic              o_crc_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q;
  logic [CRC_W-1:0]    crc_q;
  logic                mode_q;
  logic [CRC_W-1:0]    rem_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept;
  logic                last_bit;
  logic                finish;
  logic [CRC_W-1:0]    rem_nxt;

  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
  assign rem_nxt  = CRC_W'(crc_step(CRC_MAX_W'(rem_q), data_q[DATA_W-1],
                                    CRC_MAX_W'(POLY), CRC_W));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort wins over completion on the same edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start)                state_d = SHIFT;
      SHIFT:   if (i_abort || last_bit)    state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_ready = (state_q == IDLE);
    accept  = (state_q == IDLE) && i_start;
    finish  = (state_q == SHIFT) && last_bit && !i_abort;
  end

  // Datapath: latch on accept, shift while in SHIFT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      crc_q  <= '0;
      mode_q <= 1'b0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      data_q <= i_data;
      crc_q  <= i_crc;
      mode_q <= i_mode;
      rem_q  <= INIT;
      cnt_q  <= '0;
    end else if (state_q == SHIFT) begin
      data_q <= data_q << 1;
      rem_q  <= rem_nxt;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers; only a completed word updates them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_done     <= 1'b0;
      o_crc_code <= '0;
      o_crc_err  <= 1'b0;
    end else begin
      o_done <= finish;
      if (finish) begin
        o_crc_code <= rem_nxt;
        o_crc_err  <= mode_q && (rem_nxt != crc_q);
      end
    end
  end

endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: scoreboard bench for crc_serial_engine. Three
// instances: default (CRC_W=4), CRC-8 INIT=0 and CRC-8 INIT=FF. Expected
// results are queued at accept and compared when o_done pulses.
module tb_crc_serial_engine;

  typedef struct {
    logic [7:0] code;
    logic       err;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [3];
  logic       mode  [3];
  logic [7:0] data  [3];
  logic [7:0] crc   [3];
  logic       abrt  [3];
  logic       rdy   [3];
  logic       done  [3];
  logic       err   [3];
  logic [3:0] code0;
  logic [7:0] code1, code2;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_serial_engine u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_mode(mode[0]),
    .i_data(data[0]), .i_crc(crc[0][3:0]), .i_abort(abrt[0]),
    .o_ready(rdy[0]), .o_done(done[0]), .o_crc_code(code0), .o_crc_err(err[0]));

  crc_serial_engine #(.DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_mode(mode[1]),
    .i_data(data[1]), .i_crc(crc[1]), .i_abort(abrt[1]),
    .o_ready(rdy[1]), .o_done(done[1]), .o_crc_code(code1), .o_crc_err(err[1]));

  crc_serial_engine #(.DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'hFF)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_mode(mode[2]),
    .i_data(data[2]), .i_crc(crc[2]), .i_abort(abrt[2]),
    .o_ready(rdy[2]), .o_done(done[2]), .o_crc_code(code2), .o_crc_err(err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: long division of INIT*x^dw + M*x^w by the full generator.
  function automatic logic [7:0] ref_crc(input int w, input logic [7:0] poly,
                                         input logic [7:0] init, input int dw,
                                         input logic [7:0] m);
    logic [63:0] v, g;
    v = (64'(init) << dw) ^ (64'(m) << w);
    g = (64'd1 << w) | 64'(poly);
    for (int i = dw + w - 1; i >= w; i--)
      if (v[i]) v = v ^ (g << (i - w));
    return v[7:0];
  endfunction

  function automatic logic [7:0] code_of(input int d);
    case (d)
      0:       return {4'h0, code0};
      1:       return code1;
      default: return code2;
    endcase
  endfunction

  task automatic push(input int d, input logic [7:0] c, input logic e, input int acc);
    exp_t x;
    x.code = c; x.err = e; x.acc = acc;
    case (d)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (done[d]) begin
        exp_t x;
        int   sz;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
          chk($sformatf("spurious_done%0d", d), 1, 0);
        end else begin
          x = (d == 0) ? q0.pop_front() : (d == 1) ? q1.pop_front() : q2.pop_front();
          chk($sformatf("code%0d", d), code_of(d), x.code);
          chk($sformatf("err%0d", d), err[d], x.err);
          chk($sformatf("latency%0d", d), cyc - x.acc, 8);
        end
      end
    end
  end

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while (!rdy[d] && n < 50) begin @(negedge clk); n++; end
    if (!rdy[d]) chk($sformatf("ready_timeout%0d", d), 0, 1);
  endtask

  // Issue one word; if exp_valid, queue its expected result.
  task automatic send(input int d, input logic [7:0] m, input logic md,
                      input logic [7:0] rc, input logic exp_valid,
                      input logic [7:0] ec, input logic ee, output int acc);
    wait_idle(d);
    start[d] = 1'b1; data[d] = m; mode[d] = md; crc[d] = rc;
    @(posedge clk); #1;
    acc = cyc;
    start[d] = 1'b0; data[d] = 8'hXX; crc[d] = 8'hXX; mode[d] = 1'bx;
    if (exp_valid) push(d, ec, ee, acc);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("drain_pending", q0.size() + q1.size() + q2.size(), 0);
  endtask

  initial begin
    int acc;
    logic [7:0] m;
    for (int d = 0; d < 3; d++) begin
      start[d] = 0; mode[d] = 0; data[d] = 0; crc[d] = 0; abrt[d] = 0;
    end
    #12;
    chk("rst_ready", rdy[0], 1);
    chk("rst_done", done[0], 0);
    chk("rst_code", code0, 0);
    chk("rst_err", err[0], 0);
    @(negedge clk); rst_n = 1'b1;

    // Generate mode, default params
    send(0, 8'hA5, 0, 0, 1, 8'h0F, 0, acc);
    @(posedge clk); #1; chk("busy_ready", rdy[0], 0);
    send(0, 8'h00, 0, 0, 1, 8'h00, 0, acc);
    send(0, 8'h01, 0, 0, 1, 8'h07, 0, acc);
    // Check mode
    send(0, 8'hA5, 1, 8'h0F, 1, 8'h0F, 0, acc);
    send(0, 8'hA5, 1, 8'h0E, 1, 8'h0F, 1, acc);
    drain();

    // Back-to-back with i_start held; second word only accepted 9 edges later
    wait_idle(0);
    start[0] = 1; data[0] = 8'hA5; mode[0] = 0; crc[0] = 0;
    @(posedge clk); #1;
    acc = cyc;
    push(0, 8'h0F, 0, acc);
    push(0, 8'h07, 0, acc + 9);
    data[0] = 8'h01;
    repeat (9) @(posedge clk);
    #1; start[0] = 0;
    chk("b2b_second_busy", rdy[0], 0);
    drain();

    // Abort at bit 4: no done, result 7 held
    send(0, 8'hA5, 0, 0, 0, 0, 0, acc);
    repeat (4) @(posedge clk);
    #1; abrt[0] = 1;
    @(posedge clk); #1; abrt[0] = 0;
    chk("abort_ready", rdy[0], 1);
    chk("abort_code_held", code0, 4'h7);
    repeat (10) @(negedge clk);
    chk("abort_no_done_ready", rdy[0], 1);

    // Abort on the completing edge wins
    send(0, 8'hA5, 0, 0, 0, 0, 0, acc);
    repeat (7) @(posedge clk);
    #1; abrt[0] = 1;
    @(posedge clk); #1; abrt[0] = 0;
    @(negedge clk);
    chk("abort_last_done", done[0], 0);
    chk("abort_last_code", code0, 4'h7);

    // Abort while idle is harmless
    abrt[0] = 1;
    send(0, 8'h01, 0, 0, 1, 8'h07, 0, acc);
    abrt[0] = 0;
    @(posedge clk); #1; chk("idle_abort_busy", rdy[0], 0);
    drain();

    // CRC-8 instances
    send(1, 8'h01, 0, 0, 1, 8'h07, 0, acc);
    send(2, 8'h00, 0, 0, 1, 8'hF3, 0, acc);
    send(1, 8'h01, 1, 8'h07, 1, 8'h07, 0, acc);
    for (int i = 0; i < 4; i++) begin
      m = 8'($urandom_range(0, 255));
      send(1, m, 0, 0, 1, ref_crc(8, 8'h07, 8'h00, 8, m), 0, acc);
      m = 8'($urandom_range(0, 255));
      send(2, m, 1, 8'h5A, 1, ref_crc(8, 8'h07, 8'hFF, 8, m),
           ref_crc(8, 8'h07, 8'hFF, 8, m) != 8'h5A, acc);
      m = 8'($urandom_range(0, 255));
      send(0, m, 0, 0, 1, ref_crc(4, 8'h07, 8'h00, 8, m), 0, acc);
    end
    drain();

    // Async reset mid-word
    send(0, 8'hA5, 0, 0, 0, 0, 0, acc);
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("arst_code", code0, 0);
    chk("arst_err", err[0], 0);
    chk("arst_done", done[0], 0);
    chk("arst_ready", rdy[0], 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send(0, 8'hA5, 0, 0, 1, 8'h0F, 0, acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
